// File: rtl/spi_sram_pkg.sv
// spi_sram_pkg: shared definitions for the SPI serial-SRAM responder.
//   - Command opcodes recognised in the first byte of a transaction.
//   - Transaction state enumeration used by the top-level FSM.
package spi_sram_pkg;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_RDMR  = 8'h05;

    typedef enum logic [2:0] {
        ST_CMD,
        ST_ADDR,
        ST_READ,
        ST_WRITE,
        ST_RDMR,
        ST_IGNORE
    } state_e;

endpackage

// File: rtl/spi_sram_mem.sv
// spi_sram_mem: byte-wide register-file memory, 2**ADDR_BITS entries.
// Ports:
//   clk_i    - system clock
//   i_we     - write enable (synchronous)
//   i_waddr  - write address
//   i_wdata  - write data
//   i_raddr  - read address (asynchronous read)
//   o_rdata  - read data
// Contents are intentionally not reset.
module spi_sram_mem #(
    parameter int unsigned ADDR_BITS = 6
) (
    input  logic                 clk_i,
    input  logic                 i_we,
    input  logic [ADDR_BITS-1:0] i_waddr,
    input  logic [7:0]           i_wdata,
    input  logic [ADDR_BITS-1:0] i_raddr,
    output logic [7:0]           o_rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_BITS;

    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/spi_sram_target.sv
// spi_sram_target: SPI mode-0 serial-SRAM responder (READ / WRITE / RDMR).
// sck/cs_n/mosi are synchronous to clk_i; sck edges are detected by sampling.
// Ports:
//   clk_i   - system clock
//   rst_ni  - asynchronous active-low reset
//   sck     - SPI clock (mode 0)
//   cs_n    - active-low chip select
//   mosi    - serial data in, MSB first
//   miso    - serial data out, MSB first
//   busy_o  - high while selected
module spi_sram_target
    import spi_sram_pkg::*;
#(
    parameter int unsigned ADDR_BITS  = 6,
    parameter logic [7:0]  MODE_VALUE = 8'h40
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sck,
    input  logic cs_n,
    input  logic mosi,
    output logic miso,
    output logic busy_o
);

    state_e               r_state;
    logic                 r_sck_q;
    logic [2:0]           r_bit_cnt;
    logic [7:0]           r_rx;
    logic [7:0]           r_tx;
    logic [23:0]          r_addr;
    logic [1:0]           r_addr_cnt;
    logic                 r_is_write;
    logic                 r_busy;

    logic                 w_rise;
    logic                 w_fall;
    logic [7:0]           w_byte;
    logic                 w_byte_done;
    logic [23:0]          w_addr_shift;
    logic [ADDR_BITS-1:0] w_addr_inc;
    logic [ADDR_BITS-1:0] w_rd_addr;
    logic                 w_we;
    logic [7:0]           w_rdata;
    logic                 w_unused_addr;

    assign w_rise       = sck & ~r_sck_q & ~cs_n;
    assign w_fall       = ~sck & r_sck_q & ~cs_n;
    // Byte as it will be after this rise, including the bit being sampled now.
    assign w_byte       = {r_rx[6:0], mosi};
    assign w_byte_done  = w_rise & (r_bit_cnt == 3'd7);
    assign w_addr_shift = {r_addr[15:0], w_byte};
    assign w_addr_inc   = r_addr[ADDR_BITS-1:0] + ADDR_BITS'(1);
    // The address phase prefetches the byte at the just-completed address so
    // the first data bit is on miso one cycle later; bursts prefetch addr+1.
    assign w_rd_addr    = (r_state == ST_ADDR) ? w_addr_shift[ADDR_BITS-1:0] : w_addr_inc;
    assign w_we         = w_byte_done & (r_state == ST_WRITE);
    // Upper address bits are kept only for address shifting; they alias away.
    assign w_unused_addr = ^r_addr[23:16];

    spi_sram_mem #(
        .ADDR_BITS (ADDR_BITS)
    ) u_mem (
        .clk_i   (clk_i),
        .i_we    (w_we),
        .i_waddr (r_addr[ADDR_BITS-1:0]),
        .i_wdata (w_byte),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ST_CMD;
            r_sck_q    <= 1'b0;
            r_bit_cnt  <= 3'd0;
            r_rx       <= 8'h00;
            r_tx       <= 8'h00;
            r_addr     <= 24'h000000;
            r_addr_cnt <= 2'd0;
            r_is_write <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_sck_q <= sck;
            r_busy  <= ~cs_n;
            if (cs_n) begin
                // Deselect aborts anything in flight, including a partial write byte.
                r_state   <= ST_CMD;
                r_bit_cnt <= 3'd0;
                r_tx      <= 8'h00;
            end else begin
                if (w_fall) begin
                    r_tx <= {r_tx[6:0], 1'b0};
                end
                if (w_rise) begin
                    r_rx      <= w_byte;
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
                if (w_byte_done) begin
                    case (r_state)
                        ST_CMD: begin
                            r_addr_cnt <= 2'd0;
                            case (w_byte)
                                CMD_READ: begin
                                    r_state    <= ST_ADDR;
                                    r_is_write <= 1'b0;
                                end
                                CMD_WRITE: begin
                                    r_state    <= ST_ADDR;
                                    r_is_write <= 1'b1;
                                end
                                CMD_RDMR: begin
                                    r_state <= ST_RDMR;
                                    r_tx    <= MODE_VALUE;
                                end
                                default: r_state <= ST_IGNORE;
                            endcase
                        end
                        ST_ADDR: begin
                            r_addr     <= w_addr_shift;
                            r_addr_cnt <= r_addr_cnt + 2'd1;
                            if (r_addr_cnt == 2'd2) begin
                                if (r_is_write) begin
                                    r_state <= ST_WRITE;
                                end else begin
                                    r_state <= ST_READ;
                                    r_tx    <= w_rdata;
                                end
                            end
                        end
                        ST_READ: begin
                            r_addr[ADDR_BITS-1:0] <= w_addr_inc;
                            r_tx                  <= w_rdata;
                        end
                        ST_WRITE: begin
                            r_addr[ADDR_BITS-1:0] <= w_addr_inc;
                        end
                        ST_RDMR: begin
                            r_tx <= MODE_VALUE;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign miso   = r_tx[7] & ~cs_n;
    assign busy_o = r_busy;

endmodule

// File: tb/tb_spi_sram_target.sv
// tb_spi_sram_target: directed plus randomized SPI transactions against a
// byte-array memory model. miso is sampled while sck is high, just before
// each falling edge, so the first data bit appears on the last address bit.
module tb_spi_sram_target;

    localparam int AB    = 6;
    localparam int DEPTH = 1 << AB;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    logic sck = 1'b0;
    logic cs_n = 1'b1;
    logic mosi = 1'b0;
    logic miso;
    logic busy_o;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] model_mem [DEPTH];
    logic [7:0] tx_bytes [$];
    logic       samples [$];
    int         busy_drop;

    spi_sram_target #(
        .ADDR_BITS  (AB),
        .MODE_VALUE (8'h40)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .sck    (sck),
        .cs_n   (cs_n),
        .mosi   (mosi),
        .miso   (miso),
        .busy_o (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Shift nbits of tx_bytes out on mosi, recording miso before each fall.
    task automatic spi_txn(input int nbits, input bit keep_sel);
        logic [7:0] b;
        samples.delete();
        busy_drop = 0;
        cs_n = 1'b0;
        @(posedge clk_i); #1;
        for (int p = 0; p < nbits; p++) begin
            b = tx_bytes[p / 8];
            mosi = b[7 - (p % 8)];
            sck = 1'b1;
            repeat (2) @(posedge clk_i); #1;
            samples.push_back(miso);
            if (busy_o !== 1'b1) busy_drop++;
            sck = 1'b0;
            repeat (2) @(posedge clk_i); #1;
        end
        if (!keep_sel) begin
            cs_n = 1'b1;
            mosi = 1'b0;
            repeat (2) @(posedge clk_i); #1;
        end
    endtask

    function automatic logic [7:0] byte_at(input int s);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[7 - i] = samples[s + i];
        return r;
    endfunction

    task automatic push_hdr(input logic [7:0] cmd, input logic [23:0] addr);
        tx_bytes.delete();
        tx_bytes.push_back(cmd);
        tx_bytes.push_back(addr[23:16]);
        tx_bytes.push_back(addr[15:8]);
        tx_bytes.push_back(addr[7:0]);
    endtask

    task automatic do_write(input logic [23:0] addr, input logic [7:0] data [$]);
        push_hdr(8'h02, addr);
        foreach (data[j]) begin
            tx_bytes.push_back(data[j]);
            model_mem[(int'(addr) + j) % DEPTH] = data[j];
        end
        spi_txn(32 + 8 * data.size(), 1'b0);
    endtask

    task automatic do_read(input string tag, input logic [23:0] addr, input int n);
        push_hdr(8'h03, addr);
        for (int j = 0; j < n; j++) tx_bytes.push_back(8'h00);
        spi_txn(32 + 8 * n, 1'b0);
        for (int j = 0; j < n; j++)
            check(tag, {24'h0, byte_at(31 + 8 * j)}, {24'h0, model_mem[(int'(addr) + j) % DEPTH]});
        check({tag, "_busy_hi"}, busy_drop, 0);
        check({tag, "_busy_lo"}, {31'h0, busy_o}, 0);
    endtask

    initial begin
        logic [7:0]  d [$];
        logic [23:0] a;
        int          ones;
        int          n;

        // Reset state
        repeat (3) @(posedge clk_i); #1;
        check("rst_miso", {31'h0, miso}, 0);
        check("rst_busy", {31'h0, busy_o}, 0);
        rst_ni = 1'b1;
        repeat (2) @(posedge clk_i); #1;

        // Fill the whole memory with one wrapping burst from a random start
        d.delete();
        for (int j = 0; j < DEPTH; j++) d.push_back(8'($urandom));
        do_write(24'($urandom), d);
        do_read("init_dump", 24'h000000, DEPTH);

        // Write then read
        d = '{8'hA7};
        do_write(24'h000005, d);
        do_read("wr_rd_05", 24'h000005, 1);

        // Burst with wrap
        d = '{8'h11, 8'h22, 8'h33};
        do_write(24'h00003E, d);
        do_read("burst_3e", 24'h00003E, 3);
        do_read("burst_00", 24'h000000, 1);

        // Alias through ignored upper address bits
        do_read("alias", 24'h123405, 1);
        check("alias_a7", {24'h0, model_mem[5]}, 32'hA7);

        // RDMR
        tx_bytes = '{8'h05, 8'h00, 8'h00};
        spi_txn(24, 1'b0);
        check("rdmr_b0", {24'h0, byte_at(7)}, 32'h40);
        check("rdmr_b1", {24'h0, byte_at(15)}, 32'h40);

        // Abort mid-write: 5 data bits then deselect
        push_hdr(8'h02, 24'h000010);
        tx_bytes.push_back(~model_mem[16]);
        spi_txn(37, 1'b0);
        do_read("abort_10", 24'h000010, 1);

        // Unknown command: miso silent, memory untouched
        tx_bytes = '{8'hFF, 8'h02, 8'h00, 8'h00, 8'h05};
        spi_txn(40, 1'b0);
        ones = 0;
        foreach (samples[i]) if (samples[i] !== 1'b0) ones++;
        check("unk_miso", ones, 0);
        do_read("unk_dump", 24'h000000, DEPTH);

        // Randomized writes, reads and mode reads
        for (int k = 0; k < 24; k++) begin
            a = 24'($urandom);
            n = $urandom_range(1, 4);
            case ($urandom_range(0, 2))
                0: begin
                    d.delete();
                    for (int j = 0; j < n; j++) d.push_back(8'($urandom));
                    do_write(a, d);
                end
                1: do_read("rand_rd", a, n);
                default: begin
                    tx_bytes = '{8'h05, 8'h00};
                    spi_txn(16, 1'b0);
                    check("rand_rdmr", {24'h0, byte_at(7)}, 32'h40);
                end
            endcase
        end

        // Reset mid-read, then the memory must still serve its data
        push_hdr(8'h03, 24'h00003E);
        tx_bytes.push_back(8'h00);
        spi_txn(36, 1'b1);
        rst_ni = 1'b0;
        #1;
        check("mid_rst_miso", {31'h0, miso}, 0);
        check("mid_rst_busy", {31'h0, busy_o}, 0);
        cs_n = 1'b1;
        sck  = 1'b0;
        repeat (2) @(posedge clk_i); #1;
        rst_ni = 1'b1;
        repeat (2) @(posedge clk_i); #1;
        do_read("post_rst", 24'h00003E, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_sram_target.md
Name: spi_sram_target

Overview:
- Synthesizable SPI serial-SRAM responder: the target end of the byte-wide SPI SRAM protocol our SPI controller initiates.
- Decodes READ/WRITE/RDMR commands with a 24-bit address and serves data from an internal register-file memory.
- Used as the on-chip SRAM stand-in for simulation and for FPGA bring-up.
- Sits directly on the controller's sck/mosi/miso and one chip select.

Parameters:
- ADDR_BITS, 6: implemented address bits; memory depth is 2**ADDR_BITS bytes; upper address bits are ignored (aliasing).
- MODE_VALUE, 8'h40: byte returned by RDMR (sequential mode).

Ports:
- clk_i  input  1  system clock; all logic on posedge.
- rst_ni  input  1  reset, asynchronous, active-low.
- sck  input  1  SPI clock, mode 0, synchronous to clk_i; high and low phases each ≥1 clk_i cycle.
- cs_n  input  1  chip select, active-low, synchronous to clk_i.
- mosi  input  1  serial data in, MSB first.
- miso  output  1  serial data out, MSB first.
- busy_o  output  1  high while a transaction is selected (cs_n low).

Behaviour:
- Reset values:
  - miso=0, busy_o=0.
  - state=CMD, bit_cnt=0, rx/tx shift registers 0, address register 0.
  - Memory contents are not reset.
- Edge detection:
  - sck_q registers sck.
  - Rise = sck & ~sck_q & ~cs_n.
  - Fall = ~sck & sck_q & ~cs_n.
- Deselect: cs_n high in any cycle forces state=CMD, bit_cnt=0, tx=0, miso=0. This aborts a transaction mid-byte; a partial write byte is discarded.
- Rise: shift rx <= {rx[6:0], mosi}; bit_cnt increments (3-bit, wraps every byte).
- Fall: shift tx <= {tx[6:0], 1'b0}.
- miso = tx[7] while cs_n low, else 0 (combinational from tx register).
- States and transitions (each transition happens on the rise that completes a byte, bit_cnt 7->0):
  - CMD: byte 0x03 -> ADDR (read); 0x02 -> ADDR (write); 0x05 -> RDMR with tx loaded with MODE_VALUE; any other byte -> IGNORE.
  - ADDR: three bytes, MSB first, into a 24-bit address register. After the third byte:
    - Read: tx loads mem[addr[ADDR_BITS-1:0]] in the same cycle, and state -> READ.
    - Write: state -> WRITE.
  - READ: on every completed byte, addr increments (wraps modulo 2**ADDR_BITS) and tx loads mem at the new address. This gives sequential bursts.
  - WRITE: on every completed byte, mem[addr] <= rx byte (including the mosi bit of that rise), then addr increments with wrap.
  - RDMR: tx reloads MODE_VALUE on every completed byte.
  - IGNORE: miso stays 0 until deselect.
- Latency: the first output bit is valid on miso one clk_i cycle after the rise that samples the last address bit, before the next sck fall. This is compatible with a controller whose sck toggles every clk_i cycle.
- Simultaneous events: if cs_n rises in the same cycle as a completing rise, deselect wins and no memory write occurs.
- Writes during the address phase are impossible. Reads of unwritten locations return X in simulation.

Decomposition:
- Package spi_sram_pkg holds:
  - Command constants CMD_READ=8'h03, CMD_WRITE=8'h02, CMD_RDMR=8'h05.
  - State enum {ST_CMD, ST_ADDR, ST_READ, ST_WRITE, ST_RDMR, ST_IGNORE}.
- One natural sub-module: spi_sram_mem, a register-file array with one write port and one asynchronous read port.

Test Plan:
- Write then read:
  - WRITE 0x02, addr 0x000005, data 0xA7; deselect.
  - READ 0x03, addr 0x000005 -> miso shifts 0xA7 during the data byte; busy_o high throughout, low after cs_n rises.
- Burst: WRITE at 0x00003E with bytes 0x11,0x22,0x33 (ADDR_BITS=6) -> later reads return 0x11 @0x3E, 0x22 @0x3F, 0x33 @0x00 (wrap).
- Alias: read at address 0x123405 returns the byte written at 0x000005.
- RDMR: command 0x05 followed by two bytes -> miso returns 0x40, 0x40.
- Abort mid-write: WRITE to 0x10 with 5 data bits sent, then cs_n high -> mem[0x10] unchanged; the next transaction decodes its command correctly.
- Unknown command: command 0xFF then 4 bytes -> miso stays 0 and memory is unchanged.
- Reset: assert rst_ni low mid-read -> miso=0 and busy_o=0 immediately; after release, a fresh READ returns the previously written data.
